stream_demux1x4: RTL

- 1-to-4 registered stream demultiplexer: the routing counterpart to the team's 2:1 select mux.
- Accepts one valid/ready input stream carrying a 2-bit destination select, and steers each word into one of four output streams.
- Each output owns a one-entry holding register, so a stalled destination blocks only traffic addressed to it.
- Sits in front of per-lane consumers in the datapath.

---
 rtl/stream_demux1x4.sv | 84 ++++++++
 1 files changed

// File: rtl/stream_demux1x4.sv
// Purpose: 1-to-4 registered stream demux. Each output has a one-entry holding slot, selected by in_sel.
// Latency: 1 cycle from accept to out_valid; no combinational path from in_data to out_data.
// Backpressure: in_ready depends only on the addressed slot, so a stalled lane blocks only traffic sent to it.
module stream_demux1x4 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [1:0]          in_sel,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]    acc_cnt
);

  // Per-slot holding state and the accepted-word counter.
  logic [3:0]        valid_q, valid_d;
  logic [DATA_W-1:0] data_q [4];
  logic [DATA_W-1:0] data_d [4];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       accept;
  logic [3:0] load;

  // The addressed slot can take a word when it is empty or is being drained this cycle.
  always_comb begin
    in_ready = ~valid_q[in_sel] | out_ready[in_sel];
    accept   = in_valid & in_ready;
    load     = 4'b0000;
    if (accept) begin
      load[in_sel] = 1'b1;
    end
  end

  // Next-state per slot: a load wins over a drain, so a full slot can be drained and refilled in the same cycle.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < 4; k++) begin
      data_d[k]  = data_q[k];
      valid_d[k] = load[k] | (valid_q[k] & ~out_ready[k]);
      if (load[k]) begin
        data_d[k] = in_data;
      end
    end
  end

  // The counter advances once per accepted word and wraps naturally at its width.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(accept);
  end

  // State registers; reset discards all held words and clears the counter immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
      cnt_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // Flatten the slot registers onto the packed output bus, slot k at bits [k*DATA_W +: DATA_W].
  always_comb begin
    out_data = '0;
    for (int k = 0; k < 4; k++) begin
      out_data[k*DATA_W +: DATA_W] = data_q[k];
    end
  end

  assign out_valid = valid_q;
  assign acc_cnt   = cnt_q;

endmodule
